// File: rtl/uart_pkg.sv
// Shared types and watchdog constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

  localparam int unsigned TO_MULT  = 12;
  localparam int unsigned TO_SLACK = 16;
  localparam int unsigned TO_W     = 20;

  // 12*65535+16 still fits in TO_W bits, so no saturation is needed.
  function automatic logic [TO_W-1:0] calc_limit(input logic [15:0] cpb);
    return TO_W'(cpb) * TO_W'(TO_MULT) + TO_W'(TO_SLACK);
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set request scanning upward from ptr_i.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  idx_o,
  output logic            vld_o
);

  int unsigned      k;
  logic [IDW-1:0]   k_idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    idx_o = ptr_i;
    vld_o = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= NREQ) k = k - NREQ;
      k_idx = IDW'(k);
      if (req_i[k_idx]) begin
        idx_o = k_idx;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin
// grants, a one-cycle start pulse and a done-or-watchdog completion.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [15:0]       clks_per_bit_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] data_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [IDW-1:0]    owner_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_byte_o,
  output logic [15:0]       tx_clks_per_bit_o,
  input  logic              tx_done_i
);

  sched_state_t    state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  win_idx;
  logic            win_vld;
  logic            done_q;
  logic            done_edge;
  logic            wd_hit;
  logic            tx_en_q;
  logic            busy_q;
  logic [NREQ-1:0] gnt_q;
  logic [7:0]      byte_q;
  logic [TO_W-1:0] timer_q;
  logic [TO_W-1:0] limit_q;

  uart_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // A done level left over from the previous byte is masked by done_q.
  assign done_edge = tx_done_i & ~done_q;
  assign wd_hit    = (timer_q == limit_q);
  assign ptr_d     = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  assign gnt_o             = gnt_q;
  assign owner_o           = owner_q;
  assign busy_o            = busy_q;
  assign tx_en_o           = tx_en_q;
  assign tx_byte_o         = byte_q;
  assign tx_clks_per_bit_o = clks_per_bit_i;
  assign timeout_o         = (state_q == WAIT_DONE) && !done_edge && wd_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      done_q  <= 1'b0;
      tx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      byte_q  <= '0;
      timer_q <= '0;
      limit_q <= '0;
    end else begin
      done_q  <= tx_done_i;
      tx_en_q <= 1'b0;
      gnt_q   <= '0;
      case (state_q)
        IDLE: begin
          if (enable_i && win_vld) begin
            byte_q  <= data_i[{win_idx, 3'b000} +: 8];
            owner_q <= win_idx;
            limit_q <= calc_limit(clks_per_bit_i);
            timer_q <= '0;
            tx_en_q <= 1'b1;
            gnt_q   <= NREQ'(1) << win_idx;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer_q <= timer_q + TO_W'(1);
          if (done_edge || wd_hit) begin
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among NREQ byte requesters.
- Picks a requester, captures its byte and issues a one-cycle tx_en pulse to the transmitter.
- Waits for the transmitter's done indication, then serves the next requester.
- A watchdog aborts the wait if done never arrives. Sits between the peripheral's byte sources (TX FIFO, debug/console path) and the uart_tx datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), derived width of the owner index; not overridden.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- enable_i  input  1  allows new grants; an in-flight byte always completes
- clks_per_bit_i  input  16  bit period in clocks; forwarded to the transmitter and used for the timeout
- req_i  input  NREQ  per-requester request, level
- data_i  input  NREQ*8  byte of requester k on bits [8k+7:8k]
- gnt_o  output  NREQ  one-hot, one-cycle pulse: requester's byte has been taken
- owner_o  output  IDW  index of the current or last-served requester
- busy_o  output  1  high whenever not in IDLE
- timeout_o  output  1  one-cycle pulse when the watchdog fires
- tx_en_o  output  1  one-cycle start pulse to the transmitter
- tx_byte_o  output  8  byte to transmit; held stable from LAUNCH until the next grant
- tx_clks_per_bit_o  output  16  combinational copy of clks_per_bit_i
- tx_done_i  input  1  transmitter done; may stay high for more than one cycle

Behaviour:
- Reset values (all outputs): gnt_o=0, owner_o=0, busy_o=0, timeout_o=0, tx_en_o=0, tx_byte_o=0. State=IDLE, priority pointer=0 (requester 0 highest), timer=0, done_q=0.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - If enable_i=1 and req_i!=0, the winner is the first set bit scanning upward, circularly, from the pointer.
  - On that clock edge: capture data_i[winner] into tx_byte_o; owner_o<=winner; compute limit = 12*clks_per_bit_i + 16 (20-bit, no overflow) and latch it; timer<=0; go to LAUNCH.
  - If enable_i=0 or no request, stay in IDLE.
- LAUNCH (exactly 1 cycle): tx_en_o=1, gnt_o[owner]=1; next state WAIT_DONE.
- WAIT_DONE:
  - tx_en_o=0; timer increments each cycle.
  - Done is a rising edge: tx_done_i=1 and done_q=0, where done_q is tx_done_i registered every cycle in all states.
  - On done: pointer<=owner+1 (mod NREQ); go to IDLE.
  - Else if timer==limit: timeout_o=1 for that cycle; pointer<=owner+1; go to IDLE.
  - Done wins over timeout in the same cycle.
- Grant latency: req seen in IDLE at edge N gives tx_en_o and gnt_o high in cycle N+1.
- The earliest next grant is the edge after the done edge. At that point the transmitter is back in IDLE and samples tx_en one cycle later. A done level still high from the previous byte cannot create a false edge, because done_q is also high.
- Requesters hold req_i and data_i stable until gnt_o. Dropping req before gnt is legal and takes nothing.
- A request asserted during LAUNCH or WAIT_DONE waits for IDLE. There is no preemption.
- enable_i falling mid-transfer: the current byte completes normally, then no further grants.
- clks_per_bit_i changing mid-transfer: timeout uses the latched limit; passthrough is immediate, and software must not change it while busy_o=1.
- Reset mid-operation: immediate return to the reset values. The in-flight byte is lost and no gnt is re-issued.
- Only one gnt_o bit is ever high, and only in LAUNCH.

Decomposition:
- Shared package uart_pkg:
  - sched_state_t enum (IDLE, LAUNCH, WAIT_DONE);
  - TO_MULT=12, TO_SLACK=16, TO_W=20.
- One sub-module, uart_rr_arb: combinational round-robin pick.
  - Inputs: req, pointer.
  - Outputs: winner index, valid.
- The FSM, timer and capture registers live in uart_tx_sched.

Test Plan:
- Single request: req_i=0001, data_i[7:0]=0xA5, cpb=4, transmitter model attached → tx_en_o pulse 1 cycle after req; gnt_o=0001 same cycle; tx_byte_o=0xA5; busy_o drops 1 cycle after done edge; serial line shows 0,1,0,1,0,0,1,0,1,1.
- Simultaneous requests: req_i=1011 held, bytes 0x10/0x11/0x13 → service order 0,1,3; then the pointer wraps to 0. No cycle has more than one gnt bit set.
- Fairness: req_i[0] held permanently, req_i[2] asserted after the first grant → grant sequence 0,2,0,2.
- Watchdog: cpb=4, tx_done_i tied 0 → timeout_o pulses exactly 64 cycles after entering WAIT_DONE; state returns to IDLE; the next requester is served afterwards.
- Stretched done: done held high for 2 cycles, new req pending → exactly one completion counted; next tx_en_o 2 cycles after the done edge; no spurious early completion.
- Reset/enable: enable_i=0 with req_i=1111 → no grant. Assert rst_ni=0 asynchronously in WAIT_DONE → outputs go to reset values without waiting for a clock edge. After release, requester 0 is served first.
